// File: rtl/shift_pkg.sv
// Shared types and helpers for the register-specified shift sequencer.
//   shift_t      : shift operation encoding as it arrives from the decoder
//   seq_state_t  : sequencer FSM states
//   eff_amount() : clamps the raw 8-bit shift amount to the number of
//                  single-bit steps that actually change the result/carry
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } seq_state_t;

  // 33 single-bit logical shifts already push every data bit plus the
  // last carry out, so anything larger behaves identically.
  localparam logic [5:0] LSL_LSR_CLAMP = 6'd33;
  // After 32 arithmetic shifts the word is all sign bits and so is the carry.
  localparam logic [5:0] ASR_CLAMP     = 6'd32;

  function automatic logic [5:0] eff_amount(input shift_t op, input logic [7:0] amount);
    logic [5:0] eff;
    case (op)
      SH_LSL, SH_LSR: eff = (amount > {2'b00, LSL_LSR_CLAMP}) ? LSL_LSR_CLAMP : amount[5:0];
      SH_ASR:         eff = (amount > {2'b00, ASR_CLAMP})     ? ASR_CLAMP     : amount[5:0];
      default:        eff = {1'b0, amount[4:0]};  // rotation is modulo 32
    endcase
    return eff;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..31 bits.
// Ports:
//   data     in  32  operand for this step
//   op       in  2   shift operation (shift_t)
//   k        in  5   bits to shift this step; 0 passes data through
//   data_out out 32  shifted operand
//   cout     out 1   last bit shifted out (0 when k==0)
module shift_step
  import shift_pkg::*;
(
  input  logic [31:0] data,
  input  shift_t      op,
  input  logic [4:0]  k,
  output logic [31:0] data_out,
  output logic        cout
);

  // Each logical/arithmetic shift is done on a 33-bit word with one extra
  // bit on the side the data leaves from, so the carry-out lands in that
  // extra bit with no variable bit-select.
  logic [32:0] lsl_ext;
  logic [32:0] lsr_ext;
  logic [32:0] asr_ext;
  logic [31:0] ror_res;

  assign lsl_ext = {1'b0, data} << k;
  assign lsr_ext = {data, 1'b0} >> k;
  assign asr_ext = $signed({data, 1'b0}) >>> k;
  assign ror_res = (data >> k) | (data << (6'd32 - {1'b0, k}));

  always_comb begin
    data_out = data;
    cout     = 1'b0;
    if (k != 5'd0) begin
      case (op)
        SH_LSL: begin
          data_out = lsl_ext[31:0];
          cout     = lsl_ext[32];
        end
        SH_LSR: begin
          data_out = lsr_ext[32:1];
          cout     = lsr_ext[0];
        end
        SH_ASR: begin
          data_out = asr_ext[32:1];
          cout     = asr_ext[0];
        end
        default: begin
          data_out = ror_res;
          cout     = ror_res[31];  // bit rotated out lands in the MSB
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle sequencer for shift-by-register instructions (LSL/LSR/ASR/ROR).
// The effective amount is consumed at most STEP bits per cycle; the result
// and ARM-style carry-out are held in DONE until the consumer takes them.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   flush                abort any in-flight operation
//   req_valid/req_ready  request handshake; req_type, req_amount, req_data,
//                        carry_in are sampled on accept
//   rsp_valid/rsp_ready  response handshake; rsp_data, rsp_carry result
//   busy                 high while an operation is in SHIFT or DONE
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int STEP  = 4,   // 1..16
  parameter int WIDTH = 32   // the carry rules assume 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_type,
  input  logic [7:0]       req_amount,
  input  logic [WIDTH-1:0] req_data,
  input  logic             carry_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             busy
);

  localparam logic [5:0] STEP_REM = 6'(STEP);

  seq_state_t       state;
  shift_t           op_reg;
  logic [5:0]       rem_reg;
  logic [WIDTH-1:0] data_reg;
  logic             carry_reg;
  logic             rsp_valid_reg;
  logic             busy_reg;

  shift_t           req_op;
  logic [5:0]       eff;
  logic [4:0]       k;
  logic [WIDTH-1:0] step_data;
  logic             step_cout;

  assign req_op = shift_t'(req_type);
  assign eff    = eff_amount(req_op, req_amount);

  // Bits to shift this cycle: the remainder, capped at STEP.
  assign k = (rem_reg < STEP_REM) ? rem_reg[4:0] : STEP_REM[4:0];

  shift_step u_step (
    .data     (data_reg),
    .op       (op_reg),
    .k        (k),
    .data_out (step_data),
    .cout     (step_cout)
  );

  assign req_ready = (state == S_IDLE) && !flush;
  assign rsp_valid = rsp_valid_reg;
  assign busy      = busy_reg;
  assign rsp_data  = data_reg;
  assign rsp_carry = carry_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_reg        <= SH_LSL;
      rem_reg       <= '0;
      data_reg      <= '0;
      carry_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (flush) begin
      // The in-flight result is dropped; data/carry keep stale values but
      // are never presented as valid again.
      state         <= S_IDLE;
      rsp_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            data_reg <= req_data;
            op_reg   <= req_op;
            rem_reg  <= eff;
            busy_reg <= 1'b1;
            if (eff == 6'd0) begin
              // Zero amount keeps the incoming carry; a nonzero rotate by a
              // multiple of 32 leaves data alone but reports bit 31.
              carry_reg     <= (req_op == SH_ROR && req_amount != 8'd0) ? req_data[WIDTH-1] : carry_in;
              state         <= S_DONE;
              rsp_valid_reg <= 1'b1;
            end else begin
              carry_reg <= carry_in;
              state     <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          data_reg  <= step_data;
          carry_reg <= step_cout;
          rem_reg   <= rem_reg - {1'b0, k};
          if (rem_reg == {1'b0, k}) begin
            state         <= S_DONE;
            rsp_valid_reg <= 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state         <= S_IDLE;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state         <= S_IDLE;
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

endmodule
